// File: rtl/thread_lsu_if.sv
// Memory-controller channel bundle between one thread's LSU and the core's
// memory controller: one read channel and one write channel, each a
// valid/ready handshake. The LSU side is the master, the controller the slave.
interface thread_lsu_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data,
    output mem_write_valid,
    output mem_write_address,
    output mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data,
    input  mem_write_valid,
    input  mem_write_address,
    input  mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/thread_lsu.sv
// Per-thread load/store unit. Issues one data-memory read (LDR) or write (STR)
// per instruction over the memory channel interface and returns loaded data
// to the register file as lsu_out. All outputs come straight from registers.
module thread_lsu #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  thread_lsu_if.master         mem,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out
);

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  lsu_state_t           state_r,     state_s;
  logic                 rd_valid_r,  rd_valid_s;
  logic [ADDR_BITS-1:0] rd_addr_r,   rd_addr_s;
  logic                 wr_valid_r,  wr_valid_s;
  logic [ADDR_BITS-1:0] wr_addr_r,   wr_addr_s;
  logic [DATA_BITS-1:0] wr_data_r,   wr_data_s;
  logic [DATA_BITS-1:0] lsu_out_r,   lsu_out_s;
  logic [ADDR_BITS-1:0] addr_s;

  // Map the rs operand onto the address bus: truncate or zero-extend.
  if (ADDR_BITS <= DATA_BITS) begin : g_addr_trunc
    assign addr_s = rs[ADDR_BITS-1:0];
  end else begin : g_addr_zext
    assign addr_s = {{(ADDR_BITS-DATA_BITS){1'b0}}, rs};
  end

  // State and output registers; enable low freezes everything, reset wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= LSU_IDLE;
      rd_valid_r <= 1'b0;
      rd_addr_r  <= '0;
      wr_valid_r <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      lsu_out_r  <= '0;
    end else if (enable) begin
      state_r    <= state_s;
      rd_valid_r <= rd_valid_s;
      rd_addr_r  <= rd_addr_s;
      wr_valid_r <= wr_valid_s;
      wr_addr_r  <= wr_addr_s;
      wr_data_r  <= wr_data_s;
      lsu_out_r  <= lsu_out_s;
    end else begin
      state_r    <= state_r;
      rd_valid_r <= rd_valid_r;
      rd_addr_r  <= rd_addr_r;
      wr_valid_r <= wr_valid_r;
      wr_addr_r  <= wr_addr_r;
      wr_data_r  <= wr_data_r;
      lsu_out_r  <= lsu_out_r;
    end
  end

  // Next-state and next-output logic for the request/wait/done sequence.
  always_comb begin
    state_s    = state_r;
    rd_valid_s = rd_valid_r;
    rd_addr_s  = rd_addr_r;
    wr_valid_s = wr_valid_r;
    wr_addr_s  = wr_addr_r;
    wr_data_s  = wr_data_r;
    lsu_out_s  = lsu_out_r;

    case (state_r)
      LSU_IDLE: begin
        // Operands are not sampled here: the register file loads rs/rt on
        // this same edge, so they are only valid one cycle later.
        if ((core_state == CORE_REQUEST) &&
            (decoded_mem_read_enable || decoded_mem_write_enable)) begin
          state_s = LSU_REQUESTING;
        end else begin
          state_s = LSU_IDLE;
        end
      end

      LSU_REQUESTING: begin
        // Read takes priority when both decodes are set. If the decode has
        // vanished there is nothing to wait for, so fall back to IDLE
        // rather than park in WAITING with no request outstanding.
        if (decoded_mem_read_enable) begin
          rd_valid_s = 1'b1;
          rd_addr_s  = addr_s;
          state_s    = LSU_WAITING;
        end else if (decoded_mem_write_enable) begin
          wr_valid_s = 1'b1;
          wr_addr_s  = addr_s;
          wr_data_s  = rt;
          state_s    = LSU_WAITING;
        end else begin
          state_s    = LSU_IDLE;
        end
      end

      LSU_WAITING: begin
        // The pending valid tells which channel we own; the other ready is
        // ignored. Address/data registers are untouched until completion.
        if (rd_valid_r) begin
          if (mem.mem_read_ready) begin
            rd_valid_s = 1'b0;
            lsu_out_s  = mem.mem_read_data;
            state_s    = LSU_DONE;
          end else begin
            state_s    = LSU_WAITING;
          end
        end else if (wr_valid_r) begin
          if (mem.mem_write_ready) begin
            wr_valid_s = 1'b0;
            state_s    = LSU_DONE;
          end else begin
            state_s    = LSU_WAITING;
          end
        end else begin
          state_s = LSU_IDLE;
        end
      end

      LSU_DONE: begin
        if (core_state == CORE_UPDATE) begin
          state_s = LSU_IDLE;
        end else begin
          state_s = LSU_DONE;
        end
      end

      default: begin
        state_s    = LSU_IDLE;
        rd_valid_s = 1'b0;
        wr_valid_s = 1'b0;
      end
    endcase
  end

  assign lsu_state             = state_r;
  assign lsu_out               = lsu_out_r;
  assign mem.mem_read_valid    = rd_valid_r;
  assign mem.mem_read_address  = rd_addr_r;
  assign mem.mem_write_valid   = wr_valid_r;
  assign mem.mem_write_address = wr_addr_r;
  assign mem.mem_write_data    = wr_data_r;

endmodule

// File: tb/tb_thread_lsu.sv
// Directed bench for thread_lsu: expected read results go into a scoreboard
// queue when a load is issued and are popped when the unit reaches DONE.
module tb_thread_lsu;

  localparam logic [2:0] CS_IDLE    = 3'b000;
  localparam logic [2:0] CS_REQUEST = 3'b011;
  localparam logic [2:0] CS_EXECUTE = 3'b101;
  localparam logic [2:0] CS_UPDATE  = 3'b110;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic       rd_en;
  logic       wr_en;
  logic [7:0] rs;
  logic [7:0] rt;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;

  int n_checks;
  int n_fail;
  logic [7:0] exp_q[$];

  thread_lsu_if #(.ADDR_BITS(8), .DATA_BITS(8)) mem_if ();

  thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs                       (rs),
    .rt                       (rt),
    .mem                      (mem_if),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected load result and compare against lsu_out.
  task automatic check_sb(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %0h expected a queued value", tag, lsu_out);
    end else begin
      e = exp_q.pop_front();
      check(tag, {8'h00, lsu_out}, {8'h00, e});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; enable = 1'b1; core_state = CS_IDLE;
    rd_en = 1'b0; wr_en = 1'b0; rs = 8'h00; rt = 8'h00;
    mem_if.mem_read_ready  = 1'b0;
    mem_if.mem_read_data   = 8'h00;
    mem_if.mem_write_ready = 1'b0;

    // Reset for two cycles with enable high.
    tick(); tick();
    check("rst_state",  {14'd0, lsu_state}, 16'h0000);
    check("rst_rvalid", {15'd0, mem_if.mem_read_valid}, 16'h0000);
    check("rst_wvalid", {15'd0, mem_if.mem_write_valid}, 16'h0000);
    check("rst_raddr",  {8'h00, mem_if.mem_read_address}, 16'h0000);
    check("rst_waddr",  {8'h00, mem_if.mem_write_address}, 16'h0000);
    check("rst_wdata",  {8'h00, mem_if.mem_write_data}, 16'h0000);
    check("rst_out",    {8'h00, lsu_out}, 16'h0000);
    reset = 1'b0;

    // REQUEST with no op decoded: stays IDLE.
    core_state = CS_REQUEST;
    tick();
    check("noop_idle", {14'd0, lsu_state}, 16'h0000);

    // Read, zero wait: rs=0x2A loaded on the REQUEST edge.
    rd_en = 1'b1;
    tick();
    rs = 8'h2A; core_state = CS_EXECUTE;
    check("rd_req_state", {14'd0, lsu_state}, 16'h0001);
    check("rd_req_valid", {15'd0, mem_if.mem_read_valid}, 16'h0000);
    tick();
    check("rd_wait_state", {14'd0, lsu_state}, 16'h0002);
    check("rd_valid_hi",   {15'd0, mem_if.mem_read_valid}, 16'h0001);
    check("rd_addr",       {8'h00, mem_if.mem_read_address}, 16'h002A);
    mem_if.mem_read_ready = 1'b1; mem_if.mem_read_data = 8'h5C;
    exp_q.push_back(8'h5C);
    tick();
    mem_if.mem_read_ready = 1'b0;
    check("rd_done_state", {14'd0, lsu_state}, 16'h0003);
    check("rd_valid_lo",   {15'd0, mem_if.mem_read_valid}, 16'h0000);
    check_sb("rd_out_5c");
    core_state = CS_UPDATE;
    tick();
    check("rd_to_idle", {14'd0, lsu_state}, 16'h0000);

    // Write with a 5-cycle stall; rs changes mid-wait to prove registering.
    rd_en = 1'b0; wr_en = 1'b1; core_state = CS_REQUEST;
    tick();
    rs = 8'h10; rt = 8'h77; core_state = CS_EXECUTE;
    check("wr_req_state", {14'd0, lsu_state}, 16'h0001);
    tick();
    rs = 8'hFF; rt = 8'hEE;
    for (int i = 0; i < 6; i++) begin
      check("wr_stall_state", {14'd0, lsu_state}, 16'h0002);
      check("wr_stall_valid", {15'd0, mem_if.mem_write_valid}, 16'h0001);
      check("wr_stall_addr",  {8'h00, mem_if.mem_write_address}, 16'h0010);
      check("wr_stall_data",  {8'h00, mem_if.mem_write_data}, 16'h0077);
      check("wr_stall_rvld",  {15'd0, mem_if.mem_read_valid}, 16'h0000);
      if (i == 5) mem_if.mem_write_ready = 1'b1;
      tick();
    end
    mem_if.mem_write_ready = 1'b0;
    check("wr_done_state", {14'd0, lsu_state}, 16'h0003);
    check("wr_valid_lo",   {15'd0, mem_if.mem_write_valid}, 16'h0000);
    check("wr_out_kept",   {8'h00, lsu_out}, 16'h005C);

    // DONE hold while core_state is not UPDATE.
    core_state = CS_IDLE;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("done_hold", {14'd0, lsu_state}, 16'h0003);
    end
    core_state = CS_UPDATE;
    tick();
    check("done_release", {14'd0, lsu_state}, 16'h0000);
    check("out_after_idle", {8'h00, lsu_out}, 16'h005C);

    // Both decodes high: read wins; enable low in WAITING freezes the unit.
    rd_en = 1'b1; wr_en = 1'b1; core_state = CS_REQUEST;
    tick();
    rs = 8'h40; rt = 8'h99; core_state = CS_EXECUTE;
    tick();
    check("both_state", {14'd0, lsu_state}, 16'h0002);
    check("both_rvalid", {15'd0, mem_if.mem_read_valid}, 16'h0001);
    check("both_raddr", {8'h00, mem_if.mem_read_address}, 16'h0040);
    check("both_wvalid", {15'd0, mem_if.mem_write_valid}, 16'h0000);
    enable = 1'b0;
    mem_if.mem_read_ready = 1'b1; mem_if.mem_read_data = 8'hAB;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_state",  {14'd0, lsu_state}, 16'h0002);
      check("frz_rvalid", {15'd0, mem_if.mem_read_valid}, 16'h0001);
      check("frz_out",    {8'h00, lsu_out}, 16'h005C);
      check("frz_wvalid", {15'd0, mem_if.mem_write_valid}, 16'h0000);
    end
    enable = 1'b1;
    exp_q.push_back(8'hAB);
    tick();
    mem_if.mem_read_ready = 1'b0;
    check("both_done", {14'd0, lsu_state}, 16'h0003);
    check("both_wvalid_end", {15'd0, mem_if.mem_write_valid}, 16'h0000);
    check_sb("both_out_ab");
    core_state = CS_UPDATE; wr_en = 1'b0;
    tick();

    // Reset while a read is pending; opposite-channel ready is ignored.
    core_state = CS_REQUEST;
    tick();
    rs = 8'h55; core_state = CS_EXECUTE;
    tick();
    mem_if.mem_write_ready = 1'b1;
    tick();
    mem_if.mem_write_ready = 1'b0;
    check("opp_ready_ign", {14'd0, lsu_state}, 16'h0002);
    check("pend_raddr", {8'h00, mem_if.mem_read_address}, 16'h0055);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_state",  {14'd0, lsu_state}, 16'h0000);
    check("mid_rst_rvalid", {15'd0, mem_if.mem_read_valid}, 16'h0000);
    check("mid_rst_out",    {8'h00, lsu_out}, 16'h0000);

    // Fresh read after reset returns 0x33.
    core_state = CS_REQUEST;
    tick();
    rs = 8'h21; core_state = CS_EXECUTE;
    tick();
    check("rd2_addr", {8'h00, mem_if.mem_read_address}, 16'h0021);
    mem_if.mem_read_ready = 1'b1; mem_if.mem_read_data = 8'h33;
    exp_q.push_back(8'h33);
    tick();
    mem_if.mem_read_ready = 1'b0;
    check("rd2_done", {14'd0, lsu_state}, 16'h0003);
    check_sb("rd2_out_33");

    check("sb_drained", exp_q.size(), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
